float_node_serial: RTL and testbench

- Time-multiplexed single-precision neuron node: one float_mult and one float_adder are reused to accumulate NUM_INPUTS products serially. Then the stored bias is added, an optional ReLU is applied, and the result is presented on a valid/ready output.
- Replaces the fully parallel per-node multiplier/adder trees in dense layers where area matters more than throughput.
- Weights and bias are runtime-loadable instead of fixed parameters.

---
 rtl/float_node_serial.sv | 202 ++++++++++++++++++++
 tb/tb_float_node_serial.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/float_node_serial.sv
// float_node_serial: serial single-precision neuron, result = act(sum_i x_i*W[i] + bias).
// Latency: out_valid two cycles after the final sample of a frame is accepted.
// Backpressure: result held in DONE until out_ready; in_ready is low from final accept to handshake.
// Ports: clk/rst_n (async active-low); in_valid/in_ready/in_data/in_last activation stream;
//   out_valid/out_ready/out_data result; w_wr_en/w_wr_addr/w_wr_data coefficient writes
//   (addr NUM_INPUTS selects bias); busy = frame in progress; protocol_err = sticky early in_last.
// Build option: define FLOAT_NODE_RELU_EN to apply ReLU to the result (otherwise raw sum).
module float_node_serial #(
  parameter int NUM_INPUTS = 15,
  parameter int IDX_W      = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_data,
  input  logic              w_wr_en,
  input  logic [IDX_W-1:0]  w_wr_addr,
  input  logic [31:0]       w_wr_data,
  output logic              busy,
  output logic              protocol_err
);

  localparam int               WDEPTH    = 2 ** IDX_W;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_INPUTS - 1);
  localparam logic [IDX_W-1:0] BIAS_ADDR = IDX_W'(NUM_INPUTS);
  localparam logic [31:0]      QNAN      = 32'h7FC0_0000;

  typedef enum logic [1:0] {ST_ACC, ST_BIAS, ST_DONE} state_t;

  // Single-precision multiply, round-to-nearest-even; subnormals flush to zero.
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic               sign, g, s;
    logic [47:0]        p;
    logic [23:0]        m;
    logic signed [9:0]  e;
    sign = a[31] ^ b[31];
    if ((&a[30:23] && |a[22:0]) || (&b[30:23] && |b[22:0])) return QNAN;
    if ((&a[30:23] && b[30:23] == 8'h00) || (&b[30:23] && a[30:23] == 8'h00)) return QNAN;
    if (&a[30:23] || &b[30:23]) return {sign, 8'hFF, 23'h0};
    if (a[30:23] == 8'h00 || b[30:23] == 8'h00) return {sign, 31'h0};
    p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127;
    if (p[47]) begin
      m = {1'b0, p[46:24]}; g = p[23]; s = |p[22:0]; e = e + 10'sd1;
    end else begin
      m = {1'b0, p[45:23]}; g = p[22]; s = |p[21:0];
    end
    m = m + 24'(g & (s | m[0]));
    // A rounding carry leaves the fraction at zero; only the exponent moves.
    if (m[23]) e = e + 10'sd1;
    if (e >= 10'sd255) return {sign, 8'hFF, 23'h0};
    if (e <= 10'sd0) return {sign, 31'h0};
    return {sign, e[7:0], m[22:0]};
  endfunction

  // Single-precision add, round-to-nearest-even with guard/round/sticky bits.
  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    logic [31:0]        x, y;
    logic [7:0]         d;
    logic [27:0]        mx, my0, my, sm;
    logic [24:0]        m;
    logic [4:0]         lz;
    logic signed [9:0]  e;
    if ((&a[30:23] && |a[22:0]) || (&b[30:23] && |b[22:0])) return QNAN;
    if (&a[30:23] && &b[30:23] && (a[31] != b[31])) return QNAN;
    if (&a[30:23]) return {a[31], 8'hFF, 23'h0};
    if (&b[30:23]) return {b[31], 8'hFF, 23'h0};
    if (a[30:23] == 8'h00 && b[30:23] == 8'h00) return {a[31] & b[31], 31'h0};
    if (a[30:23] == 8'h00) return b;
    if (b[30:23] == 8'h00) return a;
    // x carries the larger magnitude, so it also gives the result sign.
    if (b[30:0] > a[30:0]) begin x = b; y = a; end
    else begin x = a; y = b; end
    d   = x[30:23] - y[30:23];
    mx  = {2'b01, x[22:0], 3'b000};
    my0 = {2'b01, y[22:0], 3'b000};
    if (d >= 8'd27) begin
      my = 28'd1;
    end else begin
      my = my0 >> d;
      my[0] = my[0] | (|(my0 & ((28'd1 << d) - 28'd1)));
    end
    e  = $signed({2'b00, x[30:23]});
    sm = (x[31] == y[31]) ? (mx + my) : (mx - my);
    if (sm == 28'd0) return 32'h0000_0000;
    if (sm[27]) begin
      sm = {1'b0, sm[27:2], sm[1] | sm[0]};
      e  = e + 10'sd1;
    end else begin
      lz = '0;
      for (int i = 0; i < 27; i++) if (sm[i]) lz = 5'(26 - i);
      sm = sm << lz;
      e  = e - $signed({5'b00000, lz});
    end
    m = {1'b0, sm[26:3]} + 25'(sm[2] & (sm[1] | sm[0] | sm[3]));
    if (m[24]) e = e + 10'sd1;
    if (e >= 10'sd255) return {x[31], 8'hFF, 23'h0};
    if (e <= 10'sd0) return 32'h0000_0000;
    return {x[31], e[7:0], m[22:0]};
  endfunction

  function automatic logic [31:0] activation(input logic [31:0] v);
`ifdef FLOAT_NODE_RELU_EN
    // -0.0 has its sign bit set and therefore maps to +0.
    return v[31] ? 32'h0000_0000 : v;
`else
    return v;
`endif
  endfunction

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [31:0]        acc_q, acc_d;
  logic [31:0]        out_dat_q, out_dat_d;
  logic               out_vld_q, out_vld_d;
  logic               perr_q, perr_d;
  logic [31:0]        bias_q;
  logic [31:0]        w_q [WDEPTH];
  logic [31:0]        add_b, sum;
  logic               accept, wr_apply;

  // The single adder is shared: product during ACC, bias during BIAS.
  assign add_b = (state_q == ST_BIAS) ? bias_q : fmul(in_data, w_q[idx_q]);
  assign sum   = fadd(acc_q, add_b);

  assign busy         = (idx_q != '0) || (state_q != ST_ACC);
  assign out_valid    = out_vld_q;
  assign out_data     = out_dat_q;
  assign protocol_err = perr_q;
  // Coefficients only change between frames so every frame sees one consistent set.
  assign wr_apply     = w_wr_en && !busy && !accept;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    acc_d     = acc_q;
    out_dat_d = out_dat_q;
    out_vld_d = out_vld_q;
    perr_d    = perr_q;
    in_ready  = 1'b0;
    accept    = 1'b0;
    case (state_q)
      ST_ACC: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept = 1'b1;
          acc_d  = sum;
          idx_d  = idx_q + IDX_W'(1);
          if (idx_q == LAST_IDX || in_last) begin
            state_d = ST_BIAS;
            idx_d   = '0;
            if (in_last && idx_q != LAST_IDX) perr_d = 1'b1;
          end
        end
      end
      ST_BIAS: begin
        acc_d     = sum;
        out_dat_d = activation(sum);
        out_vld_d = 1'b1;
        state_d   = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          out_vld_d = 1'b0;
          acc_d     = '0;
          state_d   = ST_ACC;
        end
      end
      default: state_d = ST_ACC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_ACC;
      idx_q     <= '0;
      acc_q     <= '0;
      out_dat_q <= '0;
      out_vld_q <= 1'b0;
      perr_q    <= 1'b0;
      bias_q    <= '0;
      for (int i = 0; i < WDEPTH; i++) w_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      acc_q     <= acc_d;
      out_dat_q <= out_dat_d;
      out_vld_q <= out_vld_d;
      perr_q    <= perr_d;
      if (wr_apply) begin
        if (w_wr_addr < BIAS_ADDR) w_q[w_wr_addr] <= w_wr_data;
        else if (w_wr_addr == BIAS_ADDR) bias_q <= w_wr_data;
      end
    end
  end

endmodule

// File: tb/tb_float_node_serial.sv
// Bench for float_node_serial: random and directed frames against a real-arithmetic model.
// Timing: inputs driven 1ns after posedge, output handshakes observed on negedge.
// Backpressure: out_ready stalls are applied per frame.
module tb_float_node_serial;
  localparam int NI = 4;
  localparam int IW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, in_last;
  logic [31:0]   in_data;
  logic          out_valid, out_ready;
  logic [31:0]   out_data;
  logic          w_wr_en;
  logic [IW-1:0] w_wr_addr;
  logic [31:0]   w_wr_data;
  logic          busy, protocol_err;

  always #5 clk = ~clk;

  float_node_serial #(.NUM_INPUTS(NI), .IDX_W(IW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .w_wr_en(w_wr_en), .w_wr_addr(w_wr_addr), .w_wr_data(w_wr_data),
    .busy(busy), .protocol_err(protocol_err)
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mw[NI];
  logic [31:0] mb;
  logic [31:0] xin[NI];

  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    logic [10:0] e;
    if (f[30:23] == 8'h00) d = {f[31], 63'h0};
    else begin
      e = 11'(f[30:23]) + 11'd896;
      d = {f[31], e, f[22:0], 29'h0};
    end
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    if (d[62:0] == 63'h0) return {d[63], 31'h0};
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  // Multiples of 0.25 in [-2,2]: all sums of NI products stay exact in single precision.
  function automatic logic [31:0] qval();
    int k;
    k = int'($urandom_range(16));
    return r2f((real'(k) - 8.0) / 4.0);
  endfunction

  function automatic logic [31:0] model(input int n);
    real         acc;
    logic [31:0] r;
    acc = 0.0;
    for (int i = 0; i < n; i++) acc = acc + f2r(xin[i]) * f2r(mw[i]);
    acc = acc + f2r(mb);
    r = r2f(acc);
`ifdef FLOAT_NODE_RELU_EN
    if (r[31]) r = 32'h0000_0000;
`endif
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic expv);
    check(name, {31'h0, act}, {31'h0, expv});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input logic [31:0] d, input bit lands);
    w_wr_en = 1'b1; w_wr_addr = IW'(a); w_wr_data = d;
    tick();
    w_wr_en = 1'b0;
    if (lands) begin
      if (a < NI) mw[a] = d;
      else if (a == NI) mb = d;
    end
  endtask

  task automatic load_all(input logic [31:0] w, input logic [31:0] b);
    for (int i = 0; i < NI; i++) wr(i, w, 1'b1);
    wr(NI, b, 1'b1);
  endtask

  task automatic load_rand();
    for (int i = 0; i < NI; i++) wr(i, qval(), 1'b1);
    wr(NI, qval(), 1'b1);
  endtask

  // wmode 1: W0 write together with the first sample; wmode 2: W0 write in a gap mid-frame.
  task automatic run_frame(input int n, input bit last, input int stall, input int wmode);
    logic [31:0] held;
    int          guard;
    bit          took;
    out_ready = (stall == 0);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1; in_data = xin[i]; in_last = last && (i == n - 1);
      if (i == 0 && wmode == 1) begin
        w_wr_en = 1'b1; w_wr_addr = '0; w_wr_data = 32'h4000_0000;
      end
      guard = 0;
      do begin
        took = in_ready;
        tick();
        guard++;
      end while (!took && guard < 50);
      if (!took) begin
        n_vec++; n_err++;
        $display("FAIL accept_timeout: sample %0d not accepted within 50 cycles", i);
      end
      in_valid = 1'b0; in_last = 1'b0; w_wr_en = 1'b0;
      if (i == 0 && wmode == 2 && n > 1) begin
        chk1("busy_mid", busy, 1'b1);
        w_wr_en = 1'b1; w_wr_addr = '0; w_wr_data = 32'h4000_0000;
        tick();
        w_wr_en = 1'b0;
      end
      if (i == n - 1) exp_q.push_back(model(n));
    end
    chk1("bias_vld", out_valid, 1'b0);
    chk1("bias_rdy", in_ready, 1'b0);
    chk1("bias_busy", busy, 1'b1);
    tick();
    chk1("lat_vld", out_valid, 1'b1);
    held = out_data;
    for (int s = 0; s < stall; s++) begin
      check("stall_dat", out_data, held);
      chk1("stall_vld", out_valid, 1'b1);
      chk1("stall_rdy", in_ready, 1'b0);
      chk1("stall_busy", busy, 1'b1);
      in_valid = 1'b1; in_data = qval();
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk1("post_vld", out_valid, 1'b0);
    chk1("post_rdy", in_ready, 1'b1);
    chk1("post_busy", busy, 1'b0);
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL out_unexpected: got %h expected no output", out_data);
          end else begin
            check("out_data", out_data, exp_q.pop_front());
          end
        end
      end
    join_none

    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b1;
    w_wr_en = 1'b0; w_wr_addr = '0; w_wr_data = '0;
    for (int i = 0; i < NI; i++) begin mw[i] = '0; xin[i] = '0; end
    mb = '0;
    repeat (3) @(posedge clk);
    #1;
    chk1("rst_vld", out_valid, 1'b0);
    check("rst_dat", out_data, 32'h0);
    chk1("rst_perr", protocol_err, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    tick();
    chk1("rst_rdy", in_ready, 1'b1);

    // Positive sum: 4 * 1.0 * 1.0 + 0.5
    load_all(32'h3F80_0000, 32'h3F00_0000);
    for (int i = 0; i < NI; i++) xin[i] = 32'h3F80_0000;
    run_frame(NI, 1'b1, 0, 0);
    chk1("pos_perr", protocol_err, 1'b0);

    // Negative sum
    load_all(32'hBF80_0000, 32'h0);
    run_frame(NI, 1'b1, 0, 0);

    // Backpressure, then a second frame without in_last (legal)
    for (int i = 0; i < NI; i++) xin[i] = qval();
    run_frame(NI, 1'b1, 5, 0);
    for (int i = 0; i < NI; i++) xin[i] = qval();
    run_frame(NI, 1'b0, 0, 0);
    chk1("nolast_perr", protocol_err, 1'b0);

    // Early in_last on the 2nd sample
    load_all(32'h3F80_0000, 32'h0);
    for (int i = 0; i < NI; i++) xin[i] = 32'h3F80_0000;
    run_frame(2, 1'b1, 0, 0);
    chk1("early_perr", protocol_err, 1'b1);
    run_frame(NI, 1'b1, 0, 0);
    chk1("sticky_perr", protocol_err, 1'b1);

    // Dropped coefficient writes: mid-frame, same cycle as a sample, out-of-range address
    xin[0] = 32'h4040_0000;
    run_frame(NI, 1'b1, 0, 2);
    run_frame(NI, 1'b1, 0, 0);
    run_frame(NI, 1'b1, 0, 1);
    wr(NI + 1, 32'h4000_0000, 1'b0);
    wr(7, 32'h4000_0000, 1'b0);
    run_frame(NI, 1'b1, 1, 0);

    // Mid-frame reset
    load_rand();
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = qval(); in_last = 1'b0;
      tick();
    end
    in_valid = 1'b0;
    chk1("pre_rst_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk1("mrst_vld", out_valid, 1'b0);
    chk1("mrst_busy", busy, 1'b0);
    chk1("mrst_perr", protocol_err, 1'b0);
    for (int i = 0; i < NI; i++) mw[i] = '0;
    mb = '0;
    tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < NI; i++) xin[i] = qval();
    run_frame(NI, 1'b1, 0, 0);
    load_rand();
    for (int i = 0; i < NI; i++) xin[i] = qval();
    run_frame(NI, 1'b1, 0, 0);
    chk1("mrst_perr_after", protocol_err, 1'b0);

    // Random frames
    for (int f = 0; f < 16; f++) begin
      int n;
      bit last;
      if ($urandom_range(2) == 0) load_rand();
      n = int'($urandom_range(NI, 1));
      last = (n < NI) ? 1'b1 : 1'($urandom_range(1));
      for (int i = 0; i < NI; i++) xin[i] = qval();
      run_frame(n, last, int'($urandom_range(3)), 0);
    end

    repeat (3) tick();
    check("queue_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
